// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: steps a 3-input circuit through all ABC vectors, captures Z into a truth table and checks it
module truth_table_sweeper #(
  parameter int HOLD_CYCLES = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       z_in,
  input  logic [7:0] expected,
  output logic [2:0] abc_out,
  output logic       busy,
  output logic       done,
  output logic [7:0] table_out,
  output logic       match
);
  localparam logic [1:0] IDLE = 2'd0, DRIVE = 2'd1, DONE = 2'd2;
  localparam logic [7:0] LAST = 8'(HOLD_CYCLES - 1);
  logic [1:0] state;
  logic [2:0] vec;
  logic [7:0] hold_cnt;
  logic       last;
  assign last = hold_cnt == LAST;
  assign abc_out = vec;
  // sweep sequencer: hold each vector, sample Z at the end of its window, then compare the table
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      vec <= '0;
      hold_cnt <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      table_out <= '0;
      match <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state <= DRIVE;
          vec <= '0;
          hold_cnt <= '0;
          busy <= 1'b1;
          table_out <= '0;
          match <= 1'b0;
        end
        DRIVE: begin
          hold_cnt <= last ? 8'd0 : hold_cnt + 8'd1;
          if (last) begin
            table_out[vec] <= z_in;
            if (vec == 3'd7) begin
              state <= DONE;
              busy <= 1'b0;
              done <= 1'b1;
            end else vec <= vec + 3'd1;
          end
        end
        DONE: begin
          match <= table_out == expected;
          done <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
